// File: rtl/commit_stream_rx.sv
// Receive side of the difftest commit stream: buffers commit records for a valid/ready reader
// and tracks the a0 shadow, cycle/instruction counters and the trap. COMMIT_PUTCH_EN enables the console strobe.
module commit_stream_rx #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmt_valid,
    input  logic [63:0]                cmt_pc,
    input  logic [31:0]                cmt_inst,
    input  logic                       cmt_wen,
    input  logic [7:0]                 cmt_wdest,
    input  logic [63:0]                cmt_wdata,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [63:0]                rec_pc,
    output logic [31:0]                rec_inst,
    output logic                       rec_wen,
    output logic [7:0]                 rec_wdest,
    output logic [63:0]                rec_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       trap,
    output logic [7:0]                 trap_code,
    output logic [63:0]                trap_pc,
    output logic [63:0]                cycle_cnt,
    output logic [63:0]                instr_cnt,
    output logic                       uart_out_valid,
    output logic [7:0]                 uart_out_ch
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
    } rec_t;

    rec_t          mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [7:0]    shadow_a0;

    logic       accept;
    logic       pop;
    logic       full;
    logic       push;
    logic       wr_a0;
    logic [7:0] eff_a0;
    rec_t       head_rec;

    assign accept = cmt_valid & ~trap;
    assign pop    = (count != '0) & rec_ready;
    assign full   = (count == CW'(DEPTH));
    // A full FIFO still takes the new record when the head leaves in the same cycle.
    assign push   = accept & (~full | pop);
    assign wr_a0  = cmt_wen & (cmt_wdest == 8'd10);
    assign eff_a0 = wr_a0 ? cmt_wdata[7:0] : shadow_a0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: cmt_pc, inst: cmt_inst, wen: cmt_wen,
                           wdest: cmt_wdest, wdata: cmt_wdata};
        end
    end

    // Head fields are forced to zero when empty so reset and drain show clean zeros.
    assign rec_valid  = (count != '0);
    assign head_rec   = rec_valid ? mem[head] : '0;
    assign rec_pc     = head_rec.pc;
    assign rec_inst   = head_rec.inst;
    assign rec_wen    = head_rec.wen;
    assign rec_wdest  = head_rec.wdest;
    assign rec_wdata  = head_rec.wdata;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            trap      <= 1'b0;
            trap_code <= 8'h0;
            trap_pc   <= 64'h0;
            cycle_cnt <= 64'h0;
            instr_cnt <= 64'h0;
            shadow_a0 <= 8'h0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (accept & ~push) overflow <= 1'b1;
            if (!trap) cycle_cnt <= cycle_cnt + 64'd1;
            if (accept) begin
                instr_cnt <= instr_cnt + 64'd1;
                if (wr_a0) shadow_a0 <= cmt_wdata[7:0];
                if (cmt_inst[6:0] == 7'h6b) begin
                    trap      <= 1'b1;
                    trap_pc   <= cmt_pc;
                    trap_code <= eff_a0;
                end
            end
        end
    end

`ifdef COMMIT_PUTCH_EN
    logic putch;
    assign putch = accept & (cmt_inst == 32'h0000007b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'h0;
        end else begin
            uart_out_valid <= putch;
            uart_out_ch    <= putch ? eff_a0 : 8'h0;
        end
    end
`else
    assign uart_out_valid = 1'b0;
    assign uart_out_ch    = 8'h0;
`endif

endmodule

// File: tb/tb_commit_stream_rx.sv
// Self-checking bench for commit_stream_rx: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_commit_stream_rx;
    localparam int DEPTH = 8;
`ifdef COMMIT_PUTCH_EN
    localparam bit PUT = 1'b1;
`else
    localparam bit PUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [63:0] cmt_pc = '0;
    logic [31:0] cmt_inst = '0;
    logic        cmt_wen = 1'b0;
    logic [7:0]  cmt_wdest = '0;
    logic [63:0] cmt_wdata = '0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    logic [63:0] rec_pc;
    logic [31:0] rec_inst;
    logic        rec_wen;
    logic [7:0]  rec_wdest;
    logic [63:0] rec_wdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        overflow;
    logic        trap;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;

    commit_stream_rx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
        .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pc(rec_pc), .rec_inst(rec_inst), .rec_wen(rec_wen),
        .rec_wdest(rec_wdest), .rec_wdata(rec_wdata),
        .fifo_count(fifo_count), .overflow(overflow),
        .trap(trap), .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue, everything else is per-beat bookkeeping.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
    } rec_t;

    rec_t        q[$];
    rec_t        r;
    bit          m_ovf, m_trap, m_uv, pop_now, acc;
    logic [7:0]  m_a0, m_tcode, m_uc, eff;
    logic [63:0] m_tpc, m_cyc, m_instr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovf = 0; m_trap = 0; m_uv = 0; m_a0 = 0; m_tcode = 0; m_uc = 0;
            m_tpc = 0; m_cyc = 0; m_instr = 0;
        end else begin
            pop_now = (q.size() != 0) && rec_ready;
            acc     = cmt_valid && !m_trap;
            eff     = (cmt_wen && cmt_wdest == 8'd10) ? cmt_wdata[7:0] : m_a0;
            m_uv = 0; m_uc = 0;
            if (!m_trap) m_cyc = m_cyc + 1;
            if (pop_now) q.delete(0);
            if (acc) begin
                m_instr = m_instr + 1;
                r.pc = cmt_pc; r.inst = cmt_inst; r.wen = cmt_wen;
                r.wdest = cmt_wdest; r.wdata = cmt_wdata;
                if (q.size() < DEPTH) q.push_back(r);
                else m_ovf = 1;
                if (cmt_wen && cmt_wdest == 8'd10) m_a0 = cmt_wdata[7:0];
                if (cmt_inst[6:0] == 7'h6b) begin
                    m_trap = 1; m_tpc = cmt_pc; m_tcode = eff;
                end
                if (PUT && cmt_inst == 32'h0000007b) begin
                    m_uv = 1; m_uc = eff;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("fifo_count", 64'(fifo_count), 64'(q.size()));
            check("rec_valid", 64'(rec_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("rec_pc", rec_pc, q[0].pc);
                check("rec_fields", {rec_inst, 7'd0, rec_wen, 16'd0, rec_wdest},
                      {q[0].inst, 7'd0, q[0].wen, 16'd0, q[0].wdest});
                check("rec_wdata", rec_wdata, q[0].wdata);
            end else begin
                check("rec_empty", rec_pc | rec_wdata | 64'(rec_inst) | 64'(rec_wen) | 64'(rec_wdest), 64'd0);
            end
            check("status", {overflow, trap, trap_code}, {m_ovf, m_trap, m_tcode});
            check("trap_pc", trap_pc, m_tpc);
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("instr_cnt", instr_cnt, m_instr);
            check("uart", {uart_out_valid, uart_out_ch}, {m_uv, m_uc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                         input bit wen, input logic [7:0] wd, input logic [63:0] data);
        cmt_valid = v; cmt_pc = pc; cmt_inst = inst;
        cmt_wen = wen; cmt_wdest = wd; cmt_wdata = data;
    endtask

    task automatic beat(input logic [63:0] pc, input logic [31:0] inst,
                        input bit wen, input logic [7:0] wd, input logic [63:0] data);
        drive(1'b1, pc, inst, wen, wd, data);
        tick();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 8'h0, 64'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 8'h0, 64'h0);
        rec_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int unsigned sel;

    initial begin
        // Basic three-beat fill and drain
        do_reset();
        check("reset_count", 64'(fifo_count), 64'd0);
        for (int i = 0; i < 3; i++) beat(64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 1'b0, 8'd0, 64'h0);
        check("t1_count", 64'(fifo_count), 64'd3);
        check("t1_head", rec_pc, 64'h8000_0000);
        check("t1_instr", instr_cnt, 64'd3);
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_drain", rec_pc, 64'h8000_0000 + 64'(4 * i));
            tick();
        end
        check("t1_empty", 64'(rec_valid), 64'd0);

        // Overflow: 10 beats into an 8-entry FIFO
        do_reset();
        for (int i = 0; i < 10; i++) beat(64'h1000 + 64'(4 * i), 32'h0000_0013, 1'b1, 8'd5, 64'(i));
        check("t2_count", 64'(fifo_count), 64'd8);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_instr", instr_cnt, 64'd10);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", rec_pc, 64'h1000 + 64'(4 * i));
            tick();
        end
        rec_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) beat(64'h3000 + 64'(4 * i), 32'h0000_0013, 1'b0, 8'd0, 64'h0);
        rec_ready = 1'b1;
        beat(64'h2000, 32'h0000_0013, 1'b0, 8'd0, 64'h0);
        rec_ready = 1'b0;
        check("t3_count", 64'(fifo_count), 64'd8);
        check("t3_ovf", 64'(overflow), 64'd0);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", rec_pc, (i < 7) ? 64'h3000 + 64'(4 * (i + 1)) : 64'h2000);
            tick();
        end
        rec_ready = 1'b0;

        // Trap with a0 shadow, then ignored beats and frozen counters
        do_reset();
        beat(64'h8000_00fc, 32'h0000_0013, 1'b1, 8'd10, 64'h1234_0000_0000_002A);
        beat(64'h8000_0100, 32'h0000_006b, 1'b0, 8'd0, 64'h0);
        check("t4_trap", 64'(trap), 64'd1);
        check("t4_code", 64'(trap_code), 64'h2A);
        check("t4_pc", trap_pc, 64'h8000_0100);
        for (int i = 0; i < 10; i++) beat(64'h9000 + 64'(i), 32'h0000_0013, 1'b1, 8'd10, 64'h77);
        check("t4_cycle", cycle_cnt, 64'd2);
        check("t4_instr", instr_cnt, 64'd2);
        check("t4_count", 64'(fifo_count), 64'd2);

        // Console putch, including back-to-back strobes
        do_reset();
        beat(64'h100, 32'h0000_0013, 1'b1, 8'd10, 64'h41);
        beat(64'h104, 32'h0000_007b, 1'b0, 8'd0, 64'h0);
        check("t5_uv", 64'(uart_out_valid), 64'(PUT));
        check("t5_uc", 64'(uart_out_ch), PUT ? 64'h41 : 64'h0);
        tick();
        check("t5_uv_off", 64'(uart_out_valid), 64'd0);
        drive(1'b1, 64'h108, 32'h0000_007b, 1'b1, 8'd10, 64'h42);
        tick();
        check("t5_b2b_a", 64'(uart_out_ch), PUT ? 64'h42 : 64'h0);
        beat(64'h10c, 32'h0000_007b, 1'b0, 8'd0, 64'h0);
        check("t5_b2b_b", {uart_out_valid, uart_out_ch}, PUT ? 64'h142 : 64'h0);
        check("t5_instr", instr_cnt, 64'd4);

        // Asynchronous reset mid-stream with entries queued and trap set
        do_reset();
        for (int i = 0; i < 3; i++) beat(64'h500 + 64'(4 * i), 32'h0000_0013, 1'b1, 8'd10, 64'h33);
        beat(64'h50c, 32'h0000_006b, 1'b0, 8'd0, 64'h0);
        check("t6_count", 64'(fifo_count), 64'd4);
        check("t6_trap", 64'(trap), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_fifo", {60'd0, fifo_count}, 64'd0);
        check("t6_rst_valid", 64'(rec_valid), 64'd0);
        check("t6_rst_flags", {overflow, trap, trap_code, uart_out_valid, uart_out_ch}, 64'd0);
        check("t6_rst_cnt", cycle_cnt | instr_cnt | trap_pc | rec_pc, 64'd0);
        tick();
        rst = 1'b1;

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            rec_ready = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 39);
            drive($urandom_range(0, 3) != 0,
                  {32'h0, $urandom},
                  (sel == 0) ? 32'h0000_006b : (sel < 4) ? 32'h0000_007b : $urandom,
                  1'($urandom),
                  (sel[1:0] == 2'd0) ? 8'd0 : (sel[1:0] == 2'd1) ? 8'd3 : 8'd10,
                  {$urandom, $urandom});
            if ($urandom_range(0, 299) == 0 || (trap && $urandom_range(0, 29) == 0)) begin
                #1;
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
            tick();
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
